// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data-SRAM responder: FSM state, lane count, width helper.
package data_sram_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int BYTE_LANES = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/data_sram_array.sv
// DEPTH x 32 synchronous RAM, byte-lane write enables, registered 1-cycle read; no reset.
module data_sram_array
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder with LATENCY wait-states and stall handshake.
// Optional address range check enabled by defining DATA_SRAM_ADDR_CHK_EN.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_stall,
  output logic        data_sram_err
);

  localparam int         ADDR_W   = clog2(DEPTH);
  localparam bit         HAS_WAIT = (LATENCY != 0);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  req_we_p1;
  logic [31:0] req_addr_p1, req_wdata_p1;
  logic        accept, commit, range_bad, is_read;
  logic        rd_valid_q;
  logic [3:0]  cmd_we;
  logic [31:0] cmd_addr, cmd_wdata, arr_rdata;

  assign accept = (state_q == IDLE) & data_sram_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && HAS_WAIT) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- request latch: held through WAIT so requester changes are ignored ----
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p1    <= data_sram_we;
      req_addr_p1  <= data_sram_addr;
      req_wdata_p1 <= data_sram_wdata;
    end
  end

  // Zero-latency commits straight from the live request at the accept edge.
  assign commit    = HAS_WAIT ? ((state_q == WAIT) && (cnt_q == 4'd0)) : accept;
  assign cmd_we    = HAS_WAIT ? req_we_p1    : data_sram_we;
  assign cmd_addr  = HAS_WAIT ? req_addr_p1  : data_sram_addr;
  assign cmd_wdata = HAS_WAIT ? req_wdata_p1 : data_sram_wdata;
  assign is_read   = (cmd_we == 4'h0);

  assign data_sram_stall = ((state_q == IDLE) & data_sram_en & HAS_WAIT) |
                           ((state_q == WAIT) & (cnt_q != 4'd0));

`ifdef DATA_SRAM_ADDR_CHK_EN
  logic err_q;
  logic unused_addr_lsb;

  assign range_bad       = |cmd_addr[31:ADDR_W+2];
  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= commit & range_bad;
  end
  assign data_sram_err = err_q;
`else
  logic unused_addr_bits;

  assign range_bad        = 1'b0;
  assign unused_addr_bits = ^{cmd_addr[31:ADDR_W+2], cmd_addr[1:0]};
  assign data_sram_err    = 1'b0;
`endif

  // ---- commit stage: RAM access and output qualification ----
  data_sram_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .wr_en (commit & ~is_read & ~range_bad & ~reset),
    .rd_en (commit & is_read & ~range_bad & ~reset),
    .be    (cmd_we),
    .addr  (cmd_addr[ADDR_W+1:2]),
    .wdata (cmd_wdata),
    .rdata (arr_rdata)
  );

  // Out-of-range reads and reset force the visible read data to zero.
  always_ff @(posedge clk) begin
    if (reset)                 rd_valid_q <= 1'b0;
    else if (commit & is_read) rd_valid_q <= ~range_bad;
  end

  assign data_sram_rdata = rd_valid_q ? arr_rdata : 32'h0;

endmodule
